adc_peak_scanner: RTL and testbench
===================================

Name: adc_peak_scanner

Overview:
Parametrised successor to the fixed four-channel ADC0809 capture and peak-hold path. It drives the ADC0809-style handshake (ALE/START/EOC/OE) and round-robin scans NUM_CH channels. It keeps the latest sample and a per-channel running extreme, either max-hold or min-hold. It adds EOC timeout detection, synchronous peak clear, and mode switching. It sits between the ADC pins and the downstream display/UART formatting logic.

Parameters:
NUM_CH, 4, channels scanned (1..8); address counts 0..NUM_CH-1.
DATA_W, 8, ADC sample width.
CLK_DIV, 8, adc_clock half-period in clock cycles (>=1).
EOC_TIMEOUT, 1023, clock cycles allowed in each EOC wait state before abort.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
eoc  in  1  ADC end-of-conversion, asynchronous to clock
adc_data  in  DATA_W  ADC output bus, valid while oe high
hold_mode  in  1  0 = max-hold, 1 = min-hold
peak_clear  in  1  synchronous one-cycle clear of peaks and timeout_err
adc_clock  out  1  divided conversion clock for the ADC
ale  out  1  address latch enable
start  out  1  conversion start
oe  out  1  ADC output enable
address  out  3  ADC channel select, upper bits 0 when NUM_CH<8
sample_data  out  NUM_CH*DATA_W  latest sample per channel, ch0 in LSBs
peak_data  out  NUM_CH*DATA_W  held extreme per channel, ch0 in LSBs
sample_valid  out  1  one-cycle strobe when a sample has been written
sample_ch  out  3  channel of the current sample_valid
timeout_err  out  1  sticky; set on any EOC timeout

Behaviour:
- Reset: every output and register is 0 (adc_clock, ale, start, oe, address, sample/peak arrays, peak_valid bits, timeout_err, sample_valid); FSM = ADDR, channel = 0.
- adc_clock: free-running divider, toggles every CLK_DIV clocks; independent of the FSM.
- eoc: 2-flop synchroniser; the FSM sees eoc_s only, 2 cycles late.
- FSM, one state per cycle unless noted:
  ADDR: address = channel; 1 cycle.
  ALE: ale = 1; 1 cycle.
  START: start = 1 for 2*CLK_DIV cycles, then go to WAIT_LO.
  WAIT_LO: wait for eoc_s = 0.
  WAIT_HI: wait for eoc_s = 1.
  READ: oe = 1 for 2 cycles; adc_data is captured on the 2nd cycle.
  UPDATE: write sample, update peak, pulse sample_valid, set sample_ch = channel, advance channel; go to ADDR.
- address holds its value from ADDR through UPDATE.
- Channel advance: channel increments by 1 and wraps from NUM_CH-1 to 0. With NUM_CH=1 it stays at 0.
- Timeout: a counter resets on entry to WAIT_LO and again on entry to WAIT_HI. If it reaches EOC_TIMEOUT in either state:
  - timeout_err is set;
  - no sample or peak write and no sample_valid;
  - the channel advances and the FSM goes to ADDR.
- Peak update in UPDATE:
  - if peak_valid[ch] = 0, load the sample and set peak_valid;
  - otherwise max mode keeps the larger value and min mode keeps the smaller, both unsigned;
  - equal values leave the peak unchanged.
- peak_clear: all peak_data = 0, all peak_valid = 0, timeout_err = 0. When coincident with UPDATE, clear wins for peaks; sample_data and sample_valid still update.
- hold_mode change: detected against a registered copy; it acts as peak_clear on the next cycle but does not clear timeout_err.
- Reset mid-conversion: the sequence aborts at once and scanning restarts at channel 0 in ADDR.
- Throughput per channel: 2*CLK_DIV + 5 cycles + EOC wait + 4 synchroniser/wait-state cycles minimum.

Test Plan:
1. NUM_CH=4, CLK_DIV=2, ADC model returns 8'h10*ch+1 -> addresses appear as 0,1,2,3,0; sample_valid pulses with sample_ch 0..3; sample_data = {8'h31,8'h21,8'h11,8'h01}.
2. Max mode, ch0 fed 8'h40, 8'h90, 8'h20 -> ch0 peak goes 40, 90, 90; the sample array ends at 20.
3. Min mode, ch2 fed 8'h80, 8'h30, 8'h30, 8'hF0 -> ch2 peak goes 80, 30, 30, 30.
4. eoc held high on ch1 with EOC_TIMEOUT=15 -> timeout_err rises 15 cycles into WAIT_LO; no sample_valid for ch1; next address is 2; peak_clear clears timeout_err.
5. peak_clear asserted in the same cycle as UPDATE on ch3 with sample 8'hAA -> sample_data[ch3] = AA, peak_data = 0, the next ch3 sample loads the peak directly.
6. Reset asserted during READ on ch2 -> all outputs 0 immediately (oe low asynchronously); after release address = 0 and ale pulses within 2 cycles.

Source files
------------

// File: rtl/adc_peak_scanner_if.sv
// ADC0809 pin bundle plus the per-channel sample/peak result bus of adc_peak_scanner.
// The scanner uses the master modport; the ADC and the downstream logic use slave.
interface adc_peak_scanner_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic                     adc_clock;
  logic                     ale;
  logic                     start;
  logic                     oe;
  logic [2:0]               address;
  logic                     eoc;
  logic [DATA_W-1:0]        adc_data;
  logic                     hold_mode;
  logic                     peak_clear;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic [NUM_CH*DATA_W-1:0] peak_data;
  logic                     sample_valid;
  logic [2:0]               sample_ch;
  logic                     timeout_err;

  modport master (
    input  eoc, adc_data, hold_mode, peak_clear,
    output adc_clock, ale, start, oe, address,
           sample_data, peak_data, sample_valid, sample_ch, timeout_err
  );

  modport slave (
    output eoc, adc_data, hold_mode, peak_clear,
    input  adc_clock, ale, start, oe, address,
           sample_data, peak_data, sample_valid, sample_ch, timeout_err
  );
endinterface

// File: rtl/adc_peak_scanner.sv
// Round-robin ADC0809 scanner: drives ALE/START/OE, waits on EOC with a timeout,
// and keeps the latest sample plus a max- or min-hold peak for every channel.
module adc_peak_scanner #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 8,
  parameter int EOC_TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  adc_peak_scanner_if.master bus
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_ALE,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_READ,
    S_UPDATE
  } state_t;

  localparam int         DIV_W     = $clog2(CLK_DIV + 1);
  localparam int         START_CYC = 2 * CLK_DIV;
  localparam int         CNT_MAX   = (START_CYC > EOC_TIMEOUT) ? START_CYC : EOC_TIMEOUT;
  localparam int         CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             adc_clock_r;

  logic             eoc_meta;
  logic             eoc_s;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       channel;
  logic [2:0]       channel_next;
  logic [2:0]       channel_inc;
  logic             capture;
  logic             do_update;
  logic             do_timeout;

  logic [DATA_W-1:0]             data_latch;
  logic [NUM_CH-1:0][DATA_W-1:0] sample_mem;
  logic [NUM_CH-1:0][DATA_W-1:0] peak_mem;
  logic [NUM_CH-1:0]             peak_valid;
  logic                          hold_mode_q;
  logic                          clear_peaks;
  logic                          timeout_err_r;
  logic                          sample_valid_r;
  logic [2:0]                    sample_ch_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      adc_clock_r <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt     <= '0;
      adc_clock_r <= ~adc_clock_r;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eoc_meta <= 1'b0;
      eoc_s    <= 1'b0;
    end else begin
      eoc_meta <= bus.eoc;
      eoc_s    <= eoc_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_ADDR;
      cnt     <= '0;
      channel <= 3'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      channel <= channel_next;
    end
  end

  assign channel_inc = (channel == LAST_CH) ? 3'd0 : channel + 3'd1;

  // The wait counter restarts on entry to each EOC wait state; a timeout fires
  // once EOC_TIMEOUT cycles have been spent in that state.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    channel_next = channel;
    capture      = 1'b0;
    do_update    = 1'b0;
    do_timeout   = 1'b0;
    case (state)
      S_ADDR: begin
        state_next = S_ALE;
      end
      S_ALE: begin
        state_next = S_START;
        cnt_next   = '0;
      end
      S_START: begin
        if (cnt == CNT_W'(START_CYC - 1)) begin
          state_next = S_WAIT_LO;
          cnt_next   = '0;
        end
      end
      S_WAIT_LO: begin
        if (!eoc_s) begin
          state_next = S_WAIT_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
          do_timeout   = 1'b1;
          state_next   = S_ADDR;
          channel_next = channel_inc;
        end
      end
      S_WAIT_HI: begin
        if (eoc_s) begin
          state_next = S_READ;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
          do_timeout   = 1'b1;
          state_next   = S_ADDR;
          channel_next = channel_inc;
        end
      end
      S_READ: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        do_update    = 1'b1;
        state_next   = S_ADDR;
        channel_next = channel_inc;
      end
      default: begin
        state_next = S_ADDR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_latch <= '0;
    end else if (capture) begin
      data_latch <= bus.adc_data;
    end
  end

  // A hold_mode flip invalidates every peak, exactly like peak_clear, but the
  // timeout flag is left alone.
  assign clear_peaks = bus.peak_clear | (bus.hold_mode != hold_mode_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_mem     <= '0;
      peak_mem       <= '0;
      peak_valid     <= '0;
      hold_mode_q    <= 1'b0;
      timeout_err_r  <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_ch_r    <= 3'd0;
    end else begin
      hold_mode_q    <= bus.hold_mode;
      sample_valid_r <= do_update;
      if (do_update) begin
        sample_ch_r <= channel;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (do_update && (channel == 3'(i))) begin
          sample_mem[i] <= data_latch;
        end
        if (clear_peaks) begin
          peak_mem[i]   <= '0;
          peak_valid[i] <= 1'b0;
        end else if (do_update && (channel == 3'(i))) begin
          if (!peak_valid[i] ||
              ( bus.hold_mode && (data_latch < peak_mem[i])) ||
              (!bus.hold_mode && (data_latch > peak_mem[i]))) begin
            peak_mem[i]   <= data_latch;
            peak_valid[i] <= 1'b1;
          end
        end
      end
      if (bus.peak_clear) begin
        timeout_err_r <= 1'b0;
      end
      if (do_timeout) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign bus.adc_clock    = adc_clock_r;
  assign bus.ale          = (state == S_ALE);
  assign bus.start        = (state == S_START);
  assign bus.oe           = (state == S_READ);
  assign bus.address      = channel;
  assign bus.sample_data  = sample_mem;
  assign bus.peak_data    = peak_mem;
  assign bus.sample_valid = sample_valid_r;
  assign bus.sample_ch    = sample_ch_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_adc_peak_scanner.sv
// Scoreboard bench for adc_peak_scanner: an ADC model consumes scripted conversions,
// a monitor pops hand-computed expectations on every sample_valid.
module tb_adc_peak_scanner;

  typedef struct packed {
    logic [7:0] data;
    logic       stuck;
  } conv_t;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] sample;
    logic [7:0] peak;
  } exp_t;

  logic  clock;
  logic  reset;
  conv_t conv_q[$];
  exp_t  exp_q[$];
  logic [2:0] addr_log[$];
  int    compare_count;
  int    fail_count;
  int    to_delta;
  int    cyc;
  int    last_start_fall;
  logic  start_d;
  logic  terr_d;
  logic  start_seen;

  adc_peak_scanner_if #(.NUM_CH(4), .DATA_W(8)) bus ();

  adc_peak_scanner #(
    .NUM_CH(4),
    .DATA_W(8),
    .CLK_DIV(2),
    .EOC_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    compare_count++;
    if (actual !== required) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stuck, input logic expect_out,
                                input logic [2:0] ch, input logic [7:0] exp_peak);
    conv_t c;
    exp_t  e;
    c.data  = data;
    c.stuck = stuck;
    conv_q.push_back(c);
    if (expect_out) begin
      e.ch     = ch;
      e.sample = data;
      e.peak   = exp_peak;
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_round(input logic [7:0] d0, input logic [7:0] p0, input logic [7:0] d1, input logic [7:0] p1,
                             input logic [7:0] d2, input logic [7:0] p2, input logic [7:0] d3, input logic [7:0] p3);
    apply_stimulus(d0, 1'b0, 1'b1, 3'd0, p0);
    apply_stimulus(d1, 1'b0, 1'b1, 3'd1, p1);
    apply_stimulus(d2, 1'b0, 1'b1, 3'd2, p2);
    apply_stimulus(d3, 1'b0, 1'b1, 3'd3, p3);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || conv_q.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    compare_count++;
    if (n >= 2000) begin
      fail_count++;
      $display("[TB] FAIL %s: actual pending=%0d required pending=0", name, exp_q.size());
    end
  endtask

  task automatic wait_for_read(input logic [2:0] ch);
    int n = 0;
    while (!(bus.oe && bus.address == ch) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check_output("read_seen", {31'd0, bus.oe}, 32'd1);
  endtask

  task automatic check_reset_state(input string name);
    check_output({name, "_ctrl"}, {26'd0, bus.adc_clock, bus.ale, bus.start, bus.oe, bus.sample_valid, bus.timeout_err}, 32'd0);
    check_output({name, "_addr"}, {29'd0, bus.address}, 32'd0);
    check_output({name, "_sample"}, bus.sample_data, 32'd0);
    check_output({name, "_peak"}, bus.peak_data, 32'd0);
  endtask

  // ADC model: EOC drops 3 cycles after START rises and returns 8 cycles later.
  initial begin : adc_model
    conv_t item;
    bus.eoc      = 1'b1;
    bus.adc_data = 8'h00;
    start_seen   = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.start && !start_seen) begin
        start_seen = 1'b1;
        repeat (3) @(negedge clock);
        if (conv_q.size() > 0) begin
          item         = conv_q.pop_front();
          bus.adc_data = item.data;
          if (!item.stuck) begin
            bus.eoc = 1'b0;
            repeat (8) @(negedge clock);
            bus.eoc = 1'b1;
          end
        end
      end else if (!bus.start) begin
        start_seen = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   idx;
    forever begin
      @(negedge clock);
      if (bus.ale) addr_log.push_back(bus.address);
      if (bus.sample_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_sample_ch", {29'd0, bus.sample_ch}, 32'hFFFF_FFFF);
        end else begin
          e   = exp_q.pop_front();
          idx = int'(e.ch) * 8;
          check_output("sample_ch", {29'd0, bus.sample_ch}, {29'd0, e.ch});
          check_output("sample_val", {24'd0, bus.sample_data[idx +: 8]}, {24'd0, e.sample});
          check_output("peak_val", {24'd0, bus.peak_data[idx +: 8]}, {24'd0, e.peak});
        end
      end
    end
  end

  initial begin : timeout_watch
    cyc             = 0;
    last_start_fall = 0;
    to_delta        = -1;
    start_d         = 1'b0;
    terr_d          = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (start_d && !bus.start) last_start_fall = cyc;
      if (bus.timeout_err && !terr_d) to_delta = cyc - last_start_fall;
      start_d = bus.start;
      terr_d  = bus.timeout_err;
    end
  end

  initial begin : main
    logic prev;
    int   toggles;
    int   found;
    int   exp_addr;
    compare_count  = 0;
    fail_count     = 0;
    reset          = 1'b1;
    bus.hold_mode  = 1'b0;
    bus.peak_clear = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");

    apply_round(8'h01, 8'h01, 8'h11, 8'h11, 8'h21, 8'h21, 8'h31, 8'h31);
    reset   = 1'b0;
    prev    = bus.adc_clock;
    toggles = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (bus.adc_clock != prev) toggles++;
      prev = bus.adc_clock;
    end
    check_output("adc_clock_toggles", toggles, 32'd8);
    wait_idle("round1");
    check_output("sample_data_r1", bus.sample_data, 32'h31211101);
    check_output("peak_data_r1", bus.peak_data, 32'h31211101);

    // Max-hold: ch0 sees 40, 90, 20.
    apply_round(8'h40, 8'h40, 8'h05, 8'h11, 8'h21, 8'h21, 8'h35, 8'h35);
    apply_round(8'h90, 8'h90, 8'h11, 8'h11, 8'h10, 8'h21, 8'h30, 8'h35);
    apply_round(8'h20, 8'h90, 8'hFF, 8'hFF, 8'h22, 8'h22, 8'h00, 8'h35);
    wait_idle("rounds2_4");
    check_output("sample_data_r4", bus.sample_data, 32'h0022FF20);
    check_output("peak_data_r4", bus.peak_data, 32'h3522FF90);

    // Min-hold: switching mode wipes peaks; ch2 sees 80, 30, 30, F0.
    bus.hold_mode = 1'b1;
    apply_round(8'h50, 8'h50, 8'h60, 8'h60, 8'h80, 8'h80, 8'h70, 8'h70);
    apply_round(8'h60, 8'h50, 8'h10, 8'h10, 8'h30, 8'h30, 8'h70, 8'h70);
    apply_round(8'h40, 8'h40, 8'h20, 8'h10, 8'h30, 8'h30, 8'hA0, 8'h70);
    apply_round(8'h50, 8'h40, 8'h10, 8'h10, 8'hF0, 8'h30, 8'h05, 8'h05);
    repeat (2) @(negedge clock);
    check_output("peak_mode_clear", bus.peak_data, 32'h0);
    wait_idle("rounds5_8");
    check_output("peak_data_r8", bus.peak_data, 32'h05301040);

    // EOC stuck high on ch1.
    apply_stimulus(8'h11, 1'b0, 1'b1, 3'd0, 8'h11);
    apply_stimulus(8'hEE, 1'b1, 1'b0, 3'd1, 8'h00);
    apply_stimulus(8'h22, 1'b0, 1'b1, 3'd2, 8'h22);
    apply_stimulus(8'h33, 1'b0, 1'b1, 3'd3, 8'h05);
    wait_idle("round9");
    check_output("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
    check_output("timeout_delay", to_delta, 32'd15);
    check_output("sample_data_r9", bus.sample_data, 32'h33221011);
    check_output("peak_data_r9", bus.peak_data, 32'h05221011);

    apply_round(8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'hAA, 8'h00);
    apply_round(8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06, 8'hBB, 8'hBB);
    bus.peak_clear = 1'b1;
    @(negedge clock);
    bus.peak_clear = 1'b0;
    check_output("timeout_err_clear", {31'd0, bus.timeout_err}, 32'd0);
    check_output("peak_clear_all", bus.peak_data, 32'h0);

    // peak_clear coincident with the ch3 UPDATE cycle.
    wait_for_read(3'd3);
    @(negedge clock);
    @(negedge clock);
    bus.peak_clear = 1'b1;
    @(negedge clock);
    bus.peak_clear = 1'b0;
    check_output("peak_after_coincident", bus.peak_data, 32'h0);
    wait_idle("rounds10_11");
    check_output("sample_data_r11", bus.sample_data, 32'hBB060504);
    check_output("peak_data_r11", bus.peak_data, 32'hBB060504);

    // Reset asserted during the ch2 READ.
    apply_stimulus(8'h12, 1'b0, 1'b1, 3'd0, 8'h04);
    apply_stimulus(8'h13, 1'b0, 1'b1, 3'd1, 8'h05);
    apply_stimulus(8'h77, 1'b0, 1'b0, 3'd2, 8'h00);
    wait_for_read(3'd2);
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid_read");
    apply_round(8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(conv_q.pop_back());
    void'(conv_q.pop_back());
    repeat (2) @(negedge clock);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (bus.ale && bus.address == 3'd0) found = 1;
    end
    check_output("ale_after_reset", found, 32'd1);
    wait_idle("round13");
    check_output("sample_data_r13", bus.sample_data, 32'h00000B0A);
    check_output("peak_data_r13", bus.peak_data, 32'h00000B0A);

    check_output("addr_log_len", {31'd0, addr_log.size() >= 49}, 32'd1);
    for (int i = 0; i < 49 && i < addr_log.size(); i++) begin
      exp_addr = (i < 44) ? (i % 4) : ((i < 47) ? (i - 44) : (i - 47));
      check_output($sformatf("addr_%0d", i), {29'd0, addr_log[i]}, exp_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
